// File: rtl/ioc_bus_arbiter.sv
// rtl/ioc_bus_arbiter.sv - two-requester round-robin arbiter and cycle sequencer for the IOC register bus
// Build option: IOC_ARB_FIXED_PRIO_EN gives requester 0 strict priority instead of round-robin.
module ioc_bus_arbiter #(
    parameter int NUM_MODULES  = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst_b,
    input  logic                     i_req0_valid,
    output logic                     o_req0_ready,
    input  logic                     i_req0_write,
    input  logic [7:0]               i_req0_addr,
    input  logic [7:0]               i_req0_wdata,
    output logic                     o_rsp0_valid,
    output logic [7:0]               o_rsp0_rdata,
    output logic                     o_rsp0_err,
    input  logic                     i_req1_valid,
    output logic                     o_req1_ready,
    input  logic                     i_req1_write,
    input  logic [7:0]               i_req1_addr,
    input  logic [7:0]               i_req1_wdata,
    output logic                     o_rsp1_valid,
    output logic [7:0]               o_rsp1_rdata,
    output logic                     o_rsp1_err,
    output logic [4:0]               o_ioc,
    output logic [7:0]               o_data_out,
    output logic [NUM_MODULES-1:0]   o_cs,
    output logic                     o_fetch_cmd,
    output logic                     o_load_cmd,
    input  logic [8*NUM_MODULES-1:0] i_mod_rdata,
    output logic                     o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

    state_t                 state, state_nxt;
    logic                   grant;
    logic                   accept;
    logic                   req_write;
    logic [7:0]             req_addr;
    logic [7:0]             req_wdata;
    logic [NUM_MODULES-1:0] req_cs;
    logic                   wr_q;
    logic                   id_q;
    logic [7:0]             addr_q;
    logic [2:0]             cnt;
    logic                   mod_ok;
    logic [7:0]             mod_rd;

`ifdef IOC_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = i_req1_valid && !i_req0_valid;
    end
`else
    logic last_grant;

    // With nobody requesting, point at the round-robin favourite so its ready is already up.
    always_comb begin
        if (i_req0_valid && i_req1_valid) grant = ~last_grant;
        else if (i_req0_valid)            grant = 1'b0;
        else if (i_req1_valid)            grant = 1'b1;
        else                              grant = ~last_grant;
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b)    last_grant <= 1'b1;
        else if (accept) last_grant <= grant;
    end
`endif

    assign o_req0_ready = (state == S_IDLE) && !grant;
    assign o_req1_ready = (state == S_IDLE) && grant;
    assign accept       = (state == S_IDLE) && (grant ? i_req1_valid : i_req0_valid);
    assign req_write    = grant ? i_req1_write : i_req0_write;
    assign req_addr     = grant ? i_req1_addr  : i_req0_addr;
    assign req_wdata    = grant ? i_req1_wdata : i_req0_wdata;
    assign mod_ok       = int'(addr_q[7:5]) < NUM_MODULES;

    // An out-of-range module index decodes to an all-zero select, which also suppresses the strobes.
    always_comb begin
        req_cs = '0;
        for (int k = 0; k < NUM_MODULES; k++) req_cs[k] = (req_addr[7:5] == 3'(k));
    end

    always_comb begin
        mod_rd = 8'h00;
        for (int k = 0; k < NUM_MODULES; k++)
            if (addr_q[7:5] == 3'(k)) mod_rd = i_mod_rdata[8*k +: 8];
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = wr_q ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == LAT_LAST) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            wr_q         <= 1'b0;
            id_q         <= 1'b0;
            addr_q       <= 8'h00;
            cnt          <= 3'd0;
            o_ioc        <= 5'd0;
            o_data_out   <= 8'h00;
            o_cs         <= '0;
            o_fetch_cmd  <= 1'b0;
            o_load_cmd   <= 1'b0;
            o_busy       <= 1'b0;
            o_rsp0_valid <= 1'b0;
            o_rsp0_rdata <= 8'h00;
            o_rsp0_err   <= 1'b0;
            o_rsp1_valid <= 1'b0;
            o_rsp1_rdata <= 8'h00;
            o_rsp1_err   <= 1'b0;
        end else begin
            o_busy      <= (state_nxt != S_IDLE);
            o_cs        <= '0;
            o_fetch_cmd <= 1'b0;
            o_load_cmd  <= 1'b0;
            if (accept) begin
                wr_q        <= req_write;
                id_q        <= grant;
                addr_q      <= req_addr;
                o_ioc       <= req_addr[4:0];
                o_data_out  <= req_wdata;
                o_cs        <= req_cs;
                o_fetch_cmd <= !req_write && (|req_cs);
                o_load_cmd  <= req_write && (|req_cs);
            end
            if (state == S_ISSUE) cnt <= 3'd0;
            else if (state == S_WAIT) cnt <= cnt + 3'd1;
            if (state_nxt == S_RESP) begin
                o_rsp0_valid <= !id_q;
                o_rsp1_valid <= id_q;
                o_rsp0_rdata <= (!id_q && !wr_q && mod_ok) ? mod_rd : 8'h00;
                o_rsp1_rdata <= (id_q && !wr_q && mod_ok) ? mod_rd : 8'h00;
                o_rsp0_err   <= !id_q && !mod_ok;
                o_rsp1_err   <= id_q && !mod_ok;
            end else begin
                o_rsp0_valid <= 1'b0;
                o_rsp1_valid <= 1'b0;
                o_rsp0_rdata <= 8'h00;
                o_rsp1_rdata <= 8'h00;
                o_rsp0_err   <= 1'b0;
                o_rsp1_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ioc_bus_arbiter.sv
// tb/tb_ioc_bus_arbiter.sv - directed vector bench for ioc_bus_arbiter
module tb_ioc_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [7:0]  req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [7:0]  rsp0_rdata, rsp1_rdata;
    logic [4:0]  ioc;
    logic [7:0]  data_out;
    logic [3:0]  cs;
    logic        fetch_cmd, load_cmd, busy;
    logic [31:0] mod_rdata;

    logic        d3_valid;
    logic [7:0]  d3_addr;
    logic        d3_ready, d3_ready1;
    logic        d3_rsp0_valid, d3_rsp0_err, d3_rsp1_valid, d3_rsp1_err;
    logic [7:0]  d3_rsp0_rdata, d3_rsp1_rdata;
    logic [4:0]  d3_ioc;
    logic [7:0]  d3_data_out;
    logic [3:0]  d3_cs;
    logic        d3_fetch, d3_load, d3_busy;
    logic [7:0]  cyc8 = 8'h00;
    logic [31:0] d3_mod_rdata;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc8 <= cyc8 + 8'd1;
    assign d3_mod_rdata = {8'h00, cyc8, 16'h0000};

    ioc_bus_arbiter dut (
        .i_sys_clk(clk), .i_rst_b(rst_b),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_write(req0_write),
        .i_req0_addr(req0_addr), .i_req0_wdata(req0_wdata),
        .o_rsp0_valid(rsp0_valid), .o_rsp0_rdata(rsp0_rdata), .o_rsp0_err(rsp0_err),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_write(req1_write),
        .i_req1_addr(req1_addr), .i_req1_wdata(req1_wdata),
        .o_rsp1_valid(rsp1_valid), .o_rsp1_rdata(rsp1_rdata), .o_rsp1_err(rsp1_err),
        .o_ioc(ioc), .o_data_out(data_out), .o_cs(cs),
        .o_fetch_cmd(fetch_cmd), .o_load_cmd(load_cmd),
        .i_mod_rdata(mod_rdata), .o_busy(busy)
    );

    ioc_bus_arbiter #(.NUM_MODULES(4), .READ_LATENCY(3)) dut3 (
        .i_sys_clk(clk), .i_rst_b(rst_b),
        .i_req0_valid(d3_valid), .o_req0_ready(d3_ready), .i_req0_write(1'b0),
        .i_req0_addr(d3_addr), .i_req0_wdata(8'h00),
        .o_rsp0_valid(d3_rsp0_valid), .o_rsp0_rdata(d3_rsp0_rdata), .o_rsp0_err(d3_rsp0_err),
        .i_req1_valid(1'b0), .o_req1_ready(d3_ready1), .i_req1_write(1'b0),
        .i_req1_addr(8'h00), .i_req1_wdata(8'h00),
        .o_rsp1_valid(d3_rsp1_valid), .o_rsp1_rdata(d3_rsp1_rdata), .o_rsp1_err(d3_rsp1_err),
        .o_ioc(d3_ioc), .o_data_out(d3_data_out), .o_cs(d3_cs),
        .o_fetch_cmd(d3_fetch), .o_load_cmd(d3_load),
        .i_mod_rdata(d3_mod_rdata), .o_busy(d3_busy)
    );

    typedef struct {
        logic        id;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [31:0] mdata;
        logic [3:0]  cs;
        logic        fetch;
        logic        load;
        logic [7:0]  rdata;
        logic        err;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy, cs, fetch_cmd, load_cmd, ioc, data_out,
                    rsp0_valid, rsp0_rdata, rsp0_err, rsp1_valid, rsp1_rdata, rsp1_err,
                    req0_ready, req1_ready});
    endfunction

    // Presents a request, waits for ready, and returns in the ISSUE cycle (T+1).
    task automatic issue(input logic id, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        int n = 0;
        if (id) begin
            req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = wdata;
        end
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", 64'(n < 20), 64'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] base;
        logic [7:0] exp8;
        logic       seen;
        logic       exp_g;
        int         n;

        vt[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 32'h04030201, 4'b0001, 1'b1, 1'b0, 8'h01, 1'b0};
        vt[1] = '{1'b1, 1'b1, 8'h24, 8'h5A, 32'h04030201, 4'b0010, 1'b0, 1'b1, 8'h00, 1'b0};
        vt[2] = '{1'b0, 1'b0, 8'hE3, 8'h00, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[3] = '{1'b1, 1'b0, 8'h7F, 8'h00, 32'hC3B2A190, 4'b1000, 1'b1, 1'b0, 8'hC3, 1'b0};
        vt[4] = '{1'b0, 1'b1, 8'h41, 8'hA5, 32'hC3B2A190, 4'b0100, 1'b0, 1'b1, 8'h00, 1'b0};
        vt[5] = '{1'b1, 1'b1, 8'h80, 8'hFF, 32'hC3B2A190, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[6] = '{1'b0, 1'b0, 8'h5E, 8'h3C, 32'h00770000, 4'b0100, 1'b1, 1'b0, 8'h77, 1'b0};

        rst_b = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
        mod_rdata = 32'h0;
        d3_valid = 1'b0; d3_addr = 8'h00;
        tick(); tick();
        check("reset_held", outs(), 64'h2);
        rst_b = 1'b1;
        tick();
        check("reset_released", outs(), 64'h2);

        for (int i = 0; i < 7; i++) begin
            mod_rdata = vt[i].mdata;
            issue(vt[i].id, vt[i].wr, vt[i].addr, vt[i].wdata);
            check($sformatf("v%0d_issue", i), 64'({cs, fetch_cmd, load_cmd, ioc, data_out, busy}),
                  64'({vt[i].cs, vt[i].fetch, vt[i].load, vt[i].addr[4:0], vt[i].wdata, 1'b1}));
            tick();
            if (!vt[i].wr) begin
                check($sformatf("v%0d_wait", i), 64'({cs, fetch_cmd, load_cmd, rsp0_valid, rsp1_valid, busy}),
                      64'({4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
                tick();
            end
            check($sformatf("v%0d_resp", i),
                  64'({rsp0_valid, rsp1_valid, (vt[i].id ? rsp1_rdata : rsp0_rdata), (vt[i].id ? rsp1_err : rsp0_err)}),
                  64'({!vt[i].id, vt[i].id, vt[i].rdata, vt[i].err}));
            tick();
            check($sformatf("v%0d_idle", i), 64'({rsp0_valid, rsp1_valid, busy, cs}), 64'd0);
        end

        // Reset pulsed while a read sits in WAIT.
        mod_rdata = 32'h0000AB00;
        issue(1'b0, 1'b0, 8'h2B, 8'h11);
        tick();
        check("rst_pre_wait", 64'({busy, ioc, data_out}), 64'({1'b1, 5'h0B, 8'h11}));
        rst_b = 1'b0;
        #1;
        check("rst_async_clear", outs(), 64'h2);
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            seen = seen | rsp0_valid | rsp1_valid;
        end
        rst_b = 1'b1;
        #1;
        check("rst_ready_first_idle", 64'({req0_ready, busy}), 64'({1'b1, 1'b0}));
        for (int k = 0; k < 5; k++) begin
            tick();
            seen = seen | rsp0_valid | rsp1_valid | busy;
        end
        check("rst_no_response", 64'(seen), 64'd0);

        // Both requesters read continuously; last_grant is fresh from reset.
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h01;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 8'h02;
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(req0_ready || req1_ready) && n < 20) begin
                tick();
                n++;
            end
`ifdef IOC_ARB_FIXED_PRIO_EN
            exp_g = 1'b0;
`else
            exp_g = g[0];
`endif
            check($sformatf("rr_grant%0d", g), 64'({n < 20, req1_ready}), 64'({1'b1, exp_g}));
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("rr_drain", 64'(busy), 64'd0);

        // READ_LATENCY=3 instance, module 2 data changes every cycle.
        d3_valid = 1'b1;
        d3_addr  = 8'h45;
        #1;
        n = 0;
        while (!d3_ready && n < 20) begin
            tick();
            n++;
        end
        check("l3_ready", 64'(n < 20), 64'd1);
        tick();
        d3_valid = 1'b0;
        base = cyc8;
        exp8 = base + 8'd3;
        check("l3_issue", 64'({d3_cs, d3_fetch, d3_ioc, d3_busy}), 64'({4'b0100, 1'b1, 5'h05, 1'b1}));
        for (int k = 2; k <= 4; k++) begin
            tick();
            check($sformatf("l3_wait%0d", k), 64'({d3_busy, d3_rsp0_valid, d3_cs, d3_fetch}),
                  64'({1'b1, 1'b0, 4'b0000, 1'b0}));
        end
        tick();
        check("l3_resp", 64'({d3_busy, d3_rsp0_valid, d3_rsp0_rdata, d3_rsp0_err, d3_rsp1_valid}),
              64'({1'b1, 1'b1, exp8, 1'b0, 1'b0}));
        tick();
        check("l3_done", 64'({d3_busy, d3_rsp0_valid}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
